// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh router constants and FSM state encoding
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 32;

  // Flit control bits
  localparam int EOP_BIT = 30;
  localparam int BOP_BIT = 29;

  // Port indices
  localparam int P_EAST  = 0;
  localparam int P_WEST  = 1;
  localparam int P_NORTH = 2;
  localparam int P_SOUTH = 3;
  localparam int P_LOCAL = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
//
// Ports:
//   req    in  NUM_IN  request vector
//   ptr    in  IDX_W   highest-priority index this cycle
//   winner out IDX_W   first set request at or after ptr, wrapping
//   any    out 1       at least one request is set
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any
);

  logic found;

  // Two passes: first the indices at or above ptr, then wrap to the bottom.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - per-output wormhole arbiter with downstream credit tracking
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   req          per-input header request for this output
//   flit_in      head flit of each input, input i at [i*FLIT_W +: FLIT_W]
//   valid_in     head flit of input i is valid
//   grant        one-hot or zero; input pops its head flit when its bit is high
//   flit_out     registered output flit
//   valid_out    flit_out valid this cycle
//   credit_in    downstream freed one buffer slot
//   busy         output locked to an input
//   credit_err   sticky; credit returned while counter already full
module output_port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic [NUM_IN-1:0]        valid_in,
  output logic [NUM_IN-1:0]        grant,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     valid_out,
  input  logic                     credit_in,
  output logic                     busy,
  output logic                     credit_err
);

  import noc_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = 3;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  state_t            state, state_next;
  logic [IW-1:0]     owner, owner_next;
  logic [IW-1:0]     ptr, ptr_next;
  logic [IW-1:0]     winner;
  logic              any_req;
  logic [CW-1:0]     credits;
  logic [FLIT_W-1:0] owner_flit;
  logic              owner_valid;
  logic              xfer;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any_req)
  );

  // Select the owner's head flit and valid.
  always_comb begin
    owner_flit  = '0;
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner == IW'(i)) begin
        owner_flit  = flit_in[i*FLIT_W +: FLIT_W];
        owner_valid = valid_in[i];
      end
    end
  end

  assign xfer = (state == ST_LOCKED) && owner_valid && (credits != '0);
  assign busy = (state == ST_LOCKED);

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (xfer && (owner == IW'(i))) grant[i] = 1'b1;
    end
  end

  // Header is only locked here; it is popped in the first LOCKED cycle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_LOCKED;
          owner_next = winner;
        end
      end
      ST_LOCKED: begin
        if (xfer && owner_flit[EOP_BIT]) begin
          state_next = ST_IDLE;
          ptr_next   = (owner == IW'(NUM_IN - 1)) ? '0 : owner + IW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      ptr        <= '0;
      credits    <= CREDITS_MAX;
      flit_out   <= '0;
      valid_out  <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      valid_out <= xfer;
      if (xfer) flit_out <= owner_flit;
      // A simultaneous transfer and credit return cancel out.
      case ({xfer, credit_in})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CREDITS_MAX) credit_err <= 1'b1;
          else                        credits    <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - scoreboard bench for output_port_arbiter
module tb_output_port_arbiter;

  localparam int NUM_IN  = 5;
  localparam int FLIT_W  = 32;
  localparam int CREDITS = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN*FLIT_W-1:0] flit_in;
  logic [NUM_IN-1:0]        valid_in;
  logic [NUM_IN-1:0]        grant;
  logic [FLIT_W-1:0]        flit_out;
  logic                     valid_out;
  logic                     credit_in;
  logic                     busy;
  logic                     credit_err;

  output_port_arbiter #(
    .NUM_IN  (NUM_IN),
    .FLIT_W  (FLIT_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flit_in    (flit_in),
    .valid_in   (valid_in),
    .grant      (grant),
    .flit_out   (flit_out),
    .valid_out  (valid_out),
    .credit_in  (credit_in),
    .busy       (busy),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  logic [FLIT_W-1:0] inq [NUM_IN][$];
  logic [FLIT_W-1:0] exp_q [$];
  int                order_q [$];
  logic [NUM_IN-1:0] hold;
  logic [NUM_IN-1:0] last_g;
  bit                auto_credit;
  int                uid = 1;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_packet(int port, int len);
    logic [FLIT_W-1:0] f;
    for (int k = 0; k < len; k++) begin
      f        = '0;
      f[30]    = (k == len - 1);
      f[29]    = (k == 0);
      f[27:8]  = 20'(uid);
      f[7:0]   = 8'(port * 16 + k);
      uid++;
      inq[port].push_back(f);
    end
  endtask

  task automatic drive_inputs();
    logic [FLIT_W-1:0] h;
    for (int i = 0; i < NUM_IN; i++) begin
      if (inq[i].size() > 0) begin
        h = inq[i][0];
        flit_in[i*FLIT_W +: FLIT_W] = h;
        valid_in[i] = !hold[i];
        req[i]      = !hold[i] && h[29] && !h[30];
      end else begin
        flit_in[i*FLIT_W +: FLIT_W] = '0;
        valid_in[i] = 1'b0;
        req[i]      = 1'b0;
      end
    end
  endtask

  // One clock: sample grant mid-cycle, predict the flit, compare output after the edge.
  task automatic step();
    int gi;
    logic [FLIT_W-1:0] hf;
    @(negedge clk);
    last_g = grant;
    gi = -1;
    for (int i = 0; i < NUM_IN; i++) if (grant[i]) gi = i;
    if (grant != '0) begin
      check_eq("grant_onehot", $countones(grant), 1);
      check_eq("grant_valid", {31'b0, valid_in[gi]}, 1);
      if (inq[gi].size() > 0) begin
        hf = inq[gi][0];
        exp_q.push_back(hf);
        if (hf[29]) order_q.push_back(gi);
      end
    end
    @(posedge clk);
    #1;
    if (valid_out) begin
      if (exp_q.size() == 0) check_eq("unexpected_flit", {31'b0, valid_out}, 0);
      else                   check_eq("flit_out", flit_out, exp_q.pop_front());
    end
    if (gi >= 0 && inq[gi].size() > 0) hf = inq[gi].pop_front();
    credit_in = auto_credit && valid_out;
    drive_inputs();
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size() + int'(busy);
    for (int i = 0; i < NUM_IN; i++) n += inq[i].size();
    return n;
  endfunction

  task automatic drain(int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_pending", pending(), 0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    hold        = '0;
    credit_in   = 1'b0;
    auto_credit = 1'b0;
    for (int i = 0; i < NUM_IN; i++) inq[i].delete();
    exp_q.delete();
    order_q.delete();
    drive_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int exp_order [6];
    hold      = '0;
    credit_in = 1'b0;
    req       = '0;
    valid_in  = '0;
    flit_in   = '0;
    reset     = 1'b1;

    // Reset state
    do_reset();
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_valid_out", {31'b0, valid_out}, 0);
    check_eq("rst_grant", {27'b0, grant}, 0);
    check_eq("rst_flit_out", flit_out, 0);
    check_eq("rst_credit_err", {31'b0, credit_err}, 0);
    check_eq("rst_credits", {29'b0, dut.credits}, CREDITS);
    check_eq("rst_ptr", {29'b0, dut.ptr}, 0);

    // Single 3-flit packet on input 0, no credit return
    add_packet(0, 3);
    drive_inputs();
    step();
    check_eq("t1_arb_grant", {27'b0, last_g}, 0);
    check_eq("t1_busy", {31'b0, busy}, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t1_grant", {27'b0, last_g}, 5'b00001);
      check_eq("t1_valid_out", {31'b0, valid_out}, 1);
    end
    check_eq("t1_busy_after", {31'b0, busy}, 0);
    check_eq("t1_credits", {29'b0, dut.credits}, 1);
    check_eq("t1_ptr", {29'b0, dut.ptr}, 1);
    step();
    check_eq("t1_idle_grant", {27'b0, last_g}, 0);
    check_eq("t1_idle_valid", {31'b0, valid_out}, 0);

    // Round-robin with inputs 0, 1, 4 requesting continuously
    do_reset();
    auto_credit = 1'b1;
    for (int r = 0; r < 2; r++) begin
      add_packet(0, 2);
      add_packet(1, 2);
      add_packet(4, 2);
    end
    drive_inputs();
    drain(200);
    exp_order = '{0, 1, 4, 0, 1, 4};
    check_eq("rr_count", order_q.size(), 6);
    for (int k = 0; k < 6 && k < order_q.size(); k++)
      check_eq($sformatf("rr_order%0d", k), order_q[k], exp_order[k]);

    // Credit stall: 6-flit packet, credits run out after 4
    do_reset();
    add_packet(2, 6);
    drive_inputs();
    step();
    ngr = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (last_g != '0) ngr++;
    end
    check_eq("stall_granted", ngr, CREDITS);
    check_eq("stall_grant", {27'b0, last_g}, 0);
    check_eq("stall_busy", {31'b0, busy}, 1);
    check_eq("stall_credits", {29'b0, dut.credits}, 0);
    credit_in = 1'b1;
    step();
    check_eq("stall_k_grant", {27'b0, last_g}, 0);
    auto_credit = 1'b1;
    step();
    check_eq("stall_k1_grant", {27'b0, last_g}, 5'b00100);
    drain(200);

    // Credit return coinciding with a transfer, then overflow
    do_reset();
    add_packet(2, 5);
    drive_inputs();
    step();
    for (int k = 0; k < 3; k++) step();
    check_eq("sim_credits_pre", {29'b0, dut.credits}, 1);
    credit_in = 1'b1;
    step();
    check_eq("sim_grant", {27'b0, last_g}, 5'b00100);
    check_eq("sim_credits", {29'b0, dut.credits}, 1);
    step();
    check_eq("sim_tail_grant", {27'b0, last_g}, 5'b00100);
    check_eq("sim_credits_zero", {29'b0, dut.credits}, 0);
    check_eq("sim_busy", {31'b0, busy}, 0);
    for (int k = 0; k < CREDITS; k++) begin
      credit_in = 1'b1;
      step();
    end
    check_eq("sim_credits_full", {29'b0, dut.credits}, CREDITS);
    check_eq("sim_err_clear", {31'b0, credit_err}, 0);
    credit_in = 1'b1;
    step();
    check_eq("ovf_err", {31'b0, credit_err}, 1);
    check_eq("ovf_credits", {29'b0, dut.credits}, CREDITS);
    step();
    check_eq("ovf_err_sticky", {31'b0, credit_err}, 1);

    // Owner bubble while another input requests
    do_reset();
    auto_credit = 1'b1;
    add_packet(0, 4);
    drive_inputs();
    step();
    step();
    check_eq("bub_hdr", {27'b0, last_g}, 5'b00001);
    step();
    check_eq("bub_body1", {27'b0, last_g}, 5'b00001);
    hold[0] = 1'b1;
    add_packet(3, 2);
    drive_inputs();
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("bub_grant", {27'b0, last_g}, 0);
      check_eq("bub_owner", {29'b0, dut.owner}, 0);
      check_eq("bub_busy", {31'b0, busy}, 1);
    end
    hold[0] = 1'b0;
    drive_inputs();
    step();
    check_eq("bub_body2", {27'b0, last_g}, 5'b00001);
    step();
    check_eq("bub_tail", {27'b0, last_g}, 5'b00001);
    step();
    check_eq("bub_arb", {27'b0, last_g}, 0);
    step();
    check_eq("bub_next", {27'b0, last_g}, 5'b01000);
    drain(100);

    // Reset in the middle of a 5-flit packet
    do_reset();
    auto_credit = 1'b1;
    add_packet(1, 5);
    drive_inputs();
    step();
    step();
    step();
    check_eq("mid_grant2", {27'b0, last_g}, 5'b00010);
    reset = 1'b1;
    step();
    check_eq("mid_valid_out", {31'b0, valid_out}, 0);
    check_eq("mid_grant", {27'b0, grant}, 0);
    check_eq("mid_busy", {31'b0, busy}, 0);
    check_eq("mid_credits", {29'b0, dut.credits}, CREDITS);
    check_eq("mid_ptr", {29'b0, dut.ptr}, 0);
    exp_q.delete();
    for (int i = 0; i < NUM_IN; i++) inq[i].delete();
    drive_inputs();
    reset = 1'b0;
    step();
    check_eq("mid_after_grant", {27'b0, last_g}, 0);
    check_eq("mid_after_valid", {31'b0, valid_out}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port wormhole arbiter and credit tracker for the 5-port mesh router. It collects the request lines that each input port's XY routing stage raises for this output (east, west, north, south or local). It picks one input by round-robin, locks the output to that input from header flit to tail flit, and forwards the flits one per cycle while downstream credits remain. One instance sits on each of the five output ports, between the input-port routing stages and the output link.

## Interface
Parameters:
- `NUM_IN`, 5, number of input ports (index 0..4 = east, west, north, south, local)
- `FLIT_W`, 32, flit width; bit 30 = eop, bit 29 = bop, [7:0] = destination row/column
- `CREDITS`, 4, downstream buffer depth in flits; the credit counter is `$clog2(CREDITS+1)` bits wide

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `req`  in  NUM_IN  per-input request for this output, from the routing stage; high only while a header flit (bop=1, eop=0) is at that input's head
- `flit_in`  in  NUM_IN*FLIT_W  head flit of each input; input i occupies bits [i*FLIT_W +: FLIT_W]
- `valid_in`  in  NUM_IN  head flit of input i is valid
- `grant`  out  NUM_IN  one-hot or zero; the input pops its head flit in any cycle where `grant[i]` is high
- `flit_out`  out  FLIT_W  registered output flit
- `valid_out`  out  1  `flit_out` is valid this cycle
- `credit_in`  in  1  single-cycle pulse; downstream freed one slot
- `busy`  out  1  output is locked to an input (state LOCKED)
- `credit_err`  out  1  sticky; set when `credit_in` arrives while the counter already equals CREDITS

## Operation
- State machine with two states: IDLE and LOCKED. Registers: `state`, `owner` (3b), `ptr` (3b round-robin pointer), `credits`, `flit_out`, `valid_out`, `credit_err`.
- **IDLE**
  - `grant` = 0.
  - If `req` is nonzero, the winner is the first set bit searching from `ptr` upward, modulo NUM_IN.
  - Next state is LOCKED with `owner` = winner.
  - The header is not consumed in the arbitration cycle.
- **LOCKED**
  - `grant[owner]` = `valid_in[owner]` && (`credits` != 0), computed combinationally from registered state. All other grant bits are 0.
  - On a transfer (grant high): next cycle `flit_out` = `flit_in[owner]` and `valid_out` = 1; `credits` decrements.
  - If the transferred flit has eop=1: next state is IDLE and `ptr` = (`owner`+1) mod NUM_IN.
  - If `valid_in[owner]` = 0 or `credits` = 0: stall in LOCKED with no timeout, and `valid_out` = 0 next cycle.
  - `req` is ignored while LOCKED, including the owner's own `req`.
- **Credits**
  - Transfer and `credit_in` in the same cycle: counter unchanged.
  - `credit_in` alone: increment, saturating at CREDITS. If the counter already equals CREDITS, hold the value and set `credit_err`.
  - Transfer alone: decrement. A transfer never occurs at 0.
- **Packets**: minimum two flits. The header has eop=0, because routing only requests on bop & !eop. Flits are forwarded unmodified.
- **Reset** (including mid-packet): state = IDLE, `owner` = 0, `ptr` = 0, `credits` = CREDITS, `flit_out` = 0, `valid_out` = 0, `credit_err` = 0. Consequently `grant` = 0 and `busy` = 0. A partially forwarded packet is abandoned; recovery is the system's responsibility.

## Timing
- `req` rises at cycle t: LOCKED at t+1. `grant` can be high at t+1, and the header appears on `flit_out` with `valid_out`=1 at t+2.
- Steady state: one flit per cycle while `valid_in[owner]` is high and credits are nonzero.
- Tail transferred at cycle u: IDLE at u+1, and arbitration for the next packet happens at u+1. Minimum gap between packets on the output link is 1 idle cycle.
- `credit_in` at cycle t is usable for a grant at t+1.
- `busy` = (`state` == LOCKED), registered.

## Structure
- Shared package `noc_pkg` holds:
  - `EOP_BIT` = 30, `BOP_BIT` = 29
  - port indices `P_EAST`=0, `P_WEST`=1, `P_NORTH`=2, `P_SOUTH`=3, `P_LOCAL`=4
  - `NUM_PORTS` = 5, `FLIT_W` = 32
  - the state encoding `ST_IDLE`=0, `ST_LOCKED`=1
- Sub-module `rr_arbiter`: combinational pick of the first set request at or after `ptr`. Inputs `req[NUM_IN]` and `ptr`; outputs `winner` index and `any`.
- The FSM, datapath register and credit counter stay in the top module.

## Test plan
- Single packet: `req`=5'b00001 with a 3-flit packet on input 0 (header, body, tail eop=1), CREDITS=4 -> `grant[0]` high for 3 consecutive cycles starting at t+1; `flit_out` carries the 3 flits at t+2..t+4; `credits` = 1; back to IDLE with `ptr`=1.
- Round-robin: `req`=5'b10011 held continuously, with 2-flit packets and ample credits -> service order is 0, 1, 4, 0.
- Credit stall: CREDITS=2, 4-flit packet, no `credit_in` -> 2 flits forwarded, then `grant`=0 and `busy`=1. A `credit_in` pulse at cycle k -> the third flit is granted at k+1.
- Simultaneous credit return and transfer: `credits`=1, a transfer plus `credit_in` in the same cycle -> `credits` stays 1. A `credit_in` pulse at `credits`=CREDITS -> `credit_err`=1, counter unchanged.
- Owner bubble: `valid_in[owner]` drops for 2 cycles mid-packet while another input raises `req` -> `grant` is all zero for those cycles, `owner` is unchanged, and no other input is granted before the tail.
- Reset mid-packet: assert `reset` after the 2nd flit of a 5-flit packet -> next cycle `valid_out`=0, `grant`=0, `busy`=0, `credits`=CREDITS, `ptr`=0.
